awmc: RTL and testbench

Automatic washing-machine controller: a Moore FSM that sequences one wash programme through fill, wash, drain, rinse and spin stages, each of fixed programmable length. The programme is gated by a lid-closed interlock and a pause input. The current stage is reported on `stage`, and completion is flagged by `done`. The block sits between the front-panel inputs and the actuator drivers, which decode `stage`.

---
 rtl/awmc_pkg.sv | 45 ++++
 rtl/awmc_stage_timer.sv | 38 +++
 rtl/awmc.sv | 91 +++++++++
 tb/tb_awmc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/awmc_pkg.sv
// Shared types and helpers for the washing-machine controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// stage_e      : 3-bit stage encoding; actuator drivers decode it directly.
// DEF_*        : default stage durations in clock cycles.
// stage_len()  : maps a stage to its duration (1 for non-timed stages).
package awmc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6
  } stage_e;

  localparam int unsigned DEF_FILL  = 4;
  localparam int unsigned DEF_WASH  = 8;
  localparam int unsigned DEF_DRAIN = 3;
  localparam int unsigned DEF_RINSE = 6;
  localparam int unsigned DEF_SPIN  = 5;

  // Non-timed stages return 1 so the timer limit is never zero.
  function automatic int unsigned stage_len(
    input stage_e      s,
    input int unsigned fill_c,
    input int unsigned wash_c,
    input int unsigned drain_c,
    input int unsigned rinse_c,
    input int unsigned spin_c
  );
    case (s)
      S_FILL:  return fill_c;
      S_WASH:  return wash_c;
      S_DRAIN: return drain_c;
      S_RINSE: return rinse_c;
      S_SPIN:  return spin_c;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/awmc_stage_timer.sv
// Per-stage cycle counter; expire flags the last cycle of the current stage.
// Latency: count updates on the edge after enable; expire is combinational on count/limit.
// Backpressure: enable low freezes the count (pause / lid-open freeze).
//
// clk, reset : clock and asynchronous active-high reset
// clear      : zero the counter on the next edge (wins over enable)
// enable     : count one cycle
// limit      : stage duration in cycles (>= 1)
// expire     : count == limit-1
module awmc_stage_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W:0]   limit,
  output logic         expire
);

  localparam logic [W:0] ONE = 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Counter is one bit narrower than limit; it never needs to reach limit itself.
  assign expire = ({1'b0, cnt} == (limit - ONE));

endmodule

// File: rtl/awmc.sv
// Washing-machine programme sequencer: IDLE->FILL->WASH->DRAIN->RINSE->SPIN->DONE->IDLE.
// Latency: start sampled at edge k gives stage=FILL after edge k; outputs registered (Moore).
// Backpressure: lid open or pause high freezes stage and counter; the stage resumes where it left off.
//
// clk, reset : clock and asynchronous active-high reset
// start      : level programme request, honoured only in IDLE
// pause      : freeze while high
// lid        : 1 = closed; open freezes the programme
// stage      : current stage code, straight from the state register
// done       : high only during the single DONE cycle
module awmc
  import awmc_pkg::*;
#(
  parameter int unsigned FILL_CYCLES  = DEF_FILL,
  parameter int unsigned WASH_CYCLES  = DEF_WASH,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN,
  parameter int unsigned RINSE_CYCLES = DEF_RINSE,
  parameter int unsigned SPIN_CYCLES  = DEF_SPIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       lid,
  output logic [2:0] stage,
  output logic       done
);

  localparam int unsigned MAX_A = (FILL_CYCLES > WASH_CYCLES) ? FILL_CYCLES : WASH_CYCLES;
  localparam int unsigned MAX_B = (DRAIN_CYCLES > RINSE_CYCLES) ? DRAIN_CYCLES : RINSE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAXC  = (MAX_C > SPIN_CYCLES) ? MAX_C : SPIN_CYCLES;
  localparam int          CW    = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  stage_e      st;
  stage_e      nxt;
  logic        run;
  logic        active;
  logic        adv;
  logic        expire;
  logic        tclear;
  logic [CW:0] limit;

  always_comb begin
    run    = lid & ~pause;
    active = 1'b0;
    case (st)
      S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: active = 1'b1;
      default:                                  active = 1'b0;
    endcase
    adv    = active & run & expire;
    // Counter is held at zero outside timed stages so each stage starts fresh.
    tclear = ~active | adv;
    limit  = (CW+1)'(stage_len(st, FILL_CYCLES, WASH_CYCLES, DRAIN_CYCLES,
                                RINSE_CYCLES, SPIN_CYCLES));

    nxt = st;
    case (st)
      S_IDLE:  if (start & run) nxt = S_FILL;
      S_FILL:  if (adv) nxt = S_WASH;
      S_WASH:  if (adv) nxt = S_DRAIN;
      S_DRAIN: if (adv) nxt = S_RINSE;
      S_RINSE: if (adv) nxt = S_SPIN;
      S_SPIN:  if (adv) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;   // illegal code 7 recovers to IDLE
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_IDLE;
      done <= 1'b0;
    end else begin
      st   <= nxt;
      done <= (nxt == S_DONE);
    end
  end

  assign stage = st;

  awmc_stage_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tclear),
    .enable (run & active),
    .limit  (limit),
    .expire (expire)
  );

endmodule

// File: tb/tb_awmc.sv
// Directed bench for awmc with default stage lengths (4/8/3/6/5).
module tb_awmc;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       start;
  logic       pause;
  logic       lid;
  logic [2:0] stage;
  logic       done;

  int checks;
  int errors;

  awmc dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pause (pause),
    .lid   (lid),
    .stage (stage),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    lid    = 1'b1;

    // Reset with no clock running
    reset = 1'b1;
    #2;
    chk("rst_stage", 32'(stage), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    #1;
    clk_en = 1'b1;

    // Idle with start low
    tickn(10);
    chk("idle_hold", 32'(stage), 0);
    chk("idle_done", 32'(done), 0);

    // Start together with pause: no start
    start = 1'b1; pause = 1'b1;
    tick();
    chk("start_pause", 32'(stage), 0);
    start = 1'b0; pause = 1'b0;

    // Full run, start at edge k
    start = 1'b1;
    tick();                                   // k
    chk("full_fill", 32'(stage), 1);
    start = 1'b0;
    tickn(3);                                 // k+3
    chk("full_fill_end", 32'(stage), 1);
    tick();                                   // k+4
    chk("full_wash", 32'(stage), 2);
    tickn(7);                                 // k+11
    chk("full_wash_end", 32'(stage), 2);
    tick();                                   // k+12
    chk("full_drain", 32'(stage), 3);
    tickn(3);                                 // k+15
    chk("full_rinse", 32'(stage), 4);
    tickn(6);                                 // k+21
    chk("full_spin", 32'(stage), 5);
    tickn(4);                                 // k+25
    chk("full_spin_end", 32'(stage), 5);
    chk("full_nodone", 32'(done), 0);
    tick();                                   // k+26
    chk("full_done_stage", 32'(stage), 6);
    chk("full_done", 32'(done), 1);
    tick();                                   // k+27
    chk("full_idle", 32'(stage), 0);
    chk("full_idle_done", 32'(done), 0);

    // Interlock: start with lid open
    lid = 1'b0; start = 1'b1;
    tickn(5);
    chk("lid_block", 32'(stage), 0);
    lid = 1'b1;
    tick();                                   // k'
    chk("lid_start", 32'(stage), 1);
    start = 1'b0;

    // Pause for 7 cycles during WASH
    tickn(4);                                 // k'+4
    chk("p_wash", 32'(stage), 2);
    tickn(2);                                 // k'+6, counter=2
    pause = 1'b1;
    tickn(7);                                 // k'+13
    chk("p_hold_stage", 32'(stage), 2);
    chk("p_hold_cnt", 32'(dut.u_timer.cnt), 2);
    pause = 1'b0;
    tickn(5);                                 // k'+18
    chk("p_wash_end", 32'(stage), 2);
    tick();                                   // k'+19
    chk("p_drain", 32'(stage), 3);
    tickn(13);                                // k'+32
    chk("p_spin_end", 32'(stage), 5);
    tick();                                   // k'+33
    chk("p_done", 32'(done), 1);
    tick();
    chk("p_idle", 32'(stage), 0);

    // Lid open for 3 cycles mid-SPIN
    start = 1'b1;
    tick();                                   // k
    start = 1'b0;
    tickn(21);                                // k+21
    chk("l_spin", 32'(stage), 5);
    tick();                                   // k+22
    lid = 1'b0;
    tickn(3);                                 // k+25
    chk("l_frozen", 32'(stage), 5);
    lid = 1'b1;
    tickn(3);                                 // k+28
    chk("l_spin_end", 32'(stage), 5);
    chk("l_nodone", 32'(done), 0);
    tick();                                   // k+29
    chk("l_done_stage", 32'(stage), 6);
    chk("l_done", 32'(done), 1);
    tick();
    chk("l_idle", 32'(stage), 0);

    // Asynchronous reset mid-RINSE
    start = 1'b1;
    tick();                                   // k
    start = 1'b0;
    tickn(16);                                // k+16
    chk("r_rinse", 32'(stage), 4);
    #1;
    reset = 1'b1;
    #1;
    chk("r_async_stage", 32'(stage), 0);
    chk("r_async_done", 32'(done), 0);
    chk("r_async_cnt", 32'(dut.u_timer.cnt), 0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    chk("r_restart", 32'(stage), 1);
    start = 1'b0;
    tickn(3);
    chk("r_fill_full", 32'(stage), 1);
    tick();
    chk("r_wash", 32'(stage), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
